sticky_event_scheduler: RTL and testbench
=========================================

STICKY_EVENT_SCHEDULER -- requirements
Module: sticky_event_scheduler

Interface
REQ-001 N_CH, 4, number of input streams; legal range 2..16.
REQ-002 TS_W, 8, timestamp width in bits.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ev_in  input  N_CH  per-channel 0/1 input stream, sampled every rising edge.
REQ-006 enable  input  N_CH  per-channel arm; when 0 the channel does not latch new 1s.
REQ-007 sticky  output  N_CH  per-channel first-1 flag; once set it stays 1 until serviced.
REQ-008 any_sticky  output  1  OR of sticky.
REQ-009 rpt_valid  output  1  report available.
REQ-010 rpt_ready  input  1  consumer accepts the report.
REQ-011 rpt_ch  output  clog2(N_CH)  channel being reported.
REQ-012 rpt_stamp  output  TS_W  time counter value captured at that channel's first 1.

Function
REQ-013 A free-running counter tcnt, width TS_W, increments every cycle and wraps from all-ones to 0.
REQ-014 sticky[i] is set at the edge where ev_in[i]=1 and enable[i]=1; set is visible one cycle later; 1-cycle latency.
REQ-015 On that setting edge, stamp[i] is loaded with tcnt; stamp[i] is not reloaded while sticky[i] stays 1.
REQ-016 The FSM has two states: IDLE and REPORT.
REQ-017 IDLE: if any sticky bit is 1, select a channel round-robin starting at pointer ptr, load rpt_ch and rpt_stamp, and go to REPORT; otherwise stay in IDLE.
REQ-018 REPORT: rpt_valid=1; rpt_ch and rpt_stamp stay stable until handshake.
REQ-019 Handshake: valid&ready at an edge clears sticky[rpt_ch], sets ptr = rpt_ch+1 mod N_CH, and returns the FSM to IDLE.
REQ-020 Outside REPORT, rpt_valid=0; at most one report every 2 cycles.
REQ-021 Clear and set on the same edge for the same channel: set wins, sticky stays 1, and stamp reloads with the current tcnt.
REQ-022 Deasserting enable does not clear sticky; it only blocks new sets.
REQ-023 New sets on other channels during REPORT are latched normally and do not disturb the current report.
REQ-024 Channels latched while the FSM is waiting are served in round-robin order; no channel waits more than N_CH reports.

Reset
REQ-025 rst=0 asynchronously forces: sticky=0, all stamps=0, tcnt=0, ptr=0, FSM=IDLE, rpt_valid=0, rpt_ch=0, rpt_stamp=0.
REQ-026 Reset mid-REPORT drops the pending report with no handshake; after release, the first set is reported normally.

Structure
REQ-027 Shared package holds the FSM state enum {IDLE, REPORT} and the default N_CH and TS_W constants.
REQ-028 One sub-module, sticky_ch, is instantiated N_CH times; each instance holds one sticky bit and one stamp register, with set, clear and set-priority per REQ-021.
REQ-029 The round-robin select, FSM and tcnt live in the top module.

Verification (N_CH=4, TS_W=8)
REQ-030 Reset release, ev_in=0001 at tcnt=5, ready=1 -> sticky=0001 next cycle, then rpt_valid with rpt_ch=0 and stamp=5, then sticky=0000.
REQ-031 ev_in=1111 same cycle, ready=1 -> reports in order ch 0,1,2,3, each 2 cycles apart; then ev_in=0011 again -> order 0,1 (ptr=0 after ch3).
REQ-032 rpt_ready held 0 for 10 cycles with ev_in[2] pulsing -> rpt_ch and rpt_stamp stable; only one report for ch2.
REQ-033 ev_in[1]=1 continuously -> after handshake sticky[1] stays 1 with new stamp (handshake tcnt); a fresh report follows.
REQ-034 enable=1110, ev_in=0001 -> no set; a 1 on ch1 at tcnt=255 then wrap -> stamp=255.
REQ-035 rst driven low while rpt_valid=1 -> all outputs 0 immediately, with no clock edge.

Source files
------------

// File: rtl/sticky_event_scheduler_pkg.sv
// Shared types and default sizing for the sticky event scheduler.
package sticky_event_scheduler_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REPORT = 1'b1
  } sched_state_e;

  localparam int DEF_N_CH = 4;
  localparam int DEF_TS_W = 8;

endpackage

// File: rtl/sticky_event_scheduler_sticky_ch.sv
// One channel: a sticky first-1 flag plus the timestamp captured when it was set.
module sticky_ch
  import sticky_event_scheduler_pkg::*;
#(
  parameter int TS_W = DEF_TS_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_i,
  input  logic            clr_i,
  input  logic [TS_W-1:0] tcnt_i,
  output logic            sticky_o,
  output logic [TS_W-1:0] stamp_o
);

  logic            sticky_q, sticky_d;
  logic [TS_W-1:0] stamp_q, stamp_d;

  // A set coinciding with a clear starts a fresh event, so it wins and restamps.
  always_comb begin
    sticky_d = sticky_q;
    stamp_d  = stamp_q;
    if (set_i) begin
      sticky_d = 1'b1;
      if (!sticky_q || clr_i) begin
        stamp_d = tcnt_i;
      end
    end else if (clr_i) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_q <= 1'b0;
      stamp_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      stamp_q  <= stamp_d;
    end
  end

  assign sticky_o = sticky_q;
  assign stamp_o  = stamp_q;

endmodule

// File: rtl/sticky_event_scheduler.sv
// Latches first-1 events per channel with a timestamp and reports them round-robin.
module sticky_event_scheduler
  import sticky_event_scheduler_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int TS_W = DEF_TS_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         ev_in,
  input  logic [N_CH-1:0]         enable,
  output logic [N_CH-1:0]         sticky,
  output logic                    any_sticky,
  output logic                    rpt_valid,
  input  logic                    rpt_ready,
  output logic [$clog2(N_CH)-1:0] rpt_ch,
  output logic [TS_W-1:0]         rpt_stamp,
  output sched_state_e            dbg_state
);

  localparam int CH_W = $clog2(N_CH);
  localparam int IW   = CH_W + 1;

  sched_state_e    state_q, state_d;
  logic [TS_W-1:0] tcnt_q;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [CH_W-1:0] rpt_ch_q, rpt_ch_d;
  logic [TS_W-1:0] rpt_stamp_q, rpt_stamp_d;
  logic [CH_W-1:0] sel_ch;
  logic            sel_found;
  logic [IW-1:0]   rr_idx;
  logic            hs;
  logic [N_CH-1:0] set_v;
  logic [N_CH-1:0] clr_v;
  logic [TS_W-1:0] stamp_w [N_CH];

  // Report handshake: rpt_valid holds with stable rpt_ch/rpt_stamp until an
  // edge sees rpt_valid & rpt_ready; that edge consumes the report.
  assign hs    = (state_q == REPORT) && rpt_ready;
  assign set_v = ev_in & enable;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign clr_v[g] = hs && (rpt_ch_q == CH_W'(g));

    sticky_ch #(
      .TS_W(TS_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .set_i   (set_v[g]),
      .clr_i   (clr_v[g]),
      .tcnt_i  (tcnt_q),
      .sticky_o(sticky[g]),
      .stamp_o (stamp_w[g])
    );
  end

  // Scan downward so the channel closest to ptr is the last one kept.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    rr_idx    = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      rr_idx = IW'(ptr_q) + IW'(k);
      if (rr_idx >= IW'(N_CH)) begin
        rr_idx = rr_idx - IW'(N_CH);
      end
      if (sticky[rr_idx[CH_W-1:0]]) begin
        sel_found = 1'b1;
        sel_ch    = rr_idx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rpt_ch_d    = rpt_ch_q;
    rpt_stamp_d = rpt_stamp_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          rpt_ch_d    = sel_ch;
          rpt_stamp_d = stamp_w[sel_ch];
          state_d     = REPORT;
        end
      end
      REPORT: begin
        if (rpt_ready) begin
          ptr_d   = (rpt_ch_q == CH_W'(N_CH - 1)) ? '0 : rpt_ch_q + CH_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      ptr_q       <= '0;
      rpt_ch_q    <= '0;
      rpt_stamp_q <= '0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_q + TS_W'(1);
      ptr_q       <= ptr_d;
      rpt_ch_q    <= rpt_ch_d;
      rpt_stamp_q <= rpt_stamp_d;
    end
  end

  assign any_sticky = |sticky;
  assign rpt_valid  = (state_q == REPORT);
  assign rpt_ch     = rpt_ch_q;
  assign rpt_stamp  = rpt_stamp_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sticky_event_scheduler.sv
// Directed bench for sticky_event_scheduler with a cycle-level reference model.
module tb_sticky_event_scheduler;
  import sticky_event_scheduler_pkg::*;

  localparam int N  = 4;
  localparam int TW = 8;
  localparam int CW = 2;
  localparam int RW = CW + TW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  ev_in = '0;
  logic [N-1:0]  enable = '1;
  logic          rpt_ready = 1'b0;
  logic [N-1:0]  sticky;
  logic          any_sticky;
  logic          rpt_valid;
  logic [CW-1:0] rpt_ch;
  logic [TW-1:0] rpt_stamp;
  sched_state_e  dbg_state;

  sticky_event_scheduler #(.N_CH(N), .TS_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ev_in     (ev_in),
    .enable    (enable),
    .sticky    (sticky),
    .any_sticky(any_sticky),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .rpt_ch    (rpt_ch),
    .rpt_stamp (rpt_stamp),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: what the scheduler must hold after each edge.
  int  m_tcnt = 0;
  int  m_ptr  = 0;
  int  m_ch   = 0;
  int  m_st   = 0;
  bit  m_busy = 1'b0;
  bit  m_sticky [N];
  int  m_stamp  [N];
  int  cyc = 0;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];
  int            got_cyc[$];

  function automatic logic [RW-1:0] rec(input int ch, input int st);
    return {CW'(ch), TW'(st)};
  endfunction

  function automatic logic [RW-1:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return '1;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < got_cyc.size()) return got_cyc[i];
    return -1;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tcnt = 0; m_ptr = 0; m_ch = 0; m_st = 0; m_busy = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_sticky[i] = 1'b0;
        m_stamp[i]  = 0;
      end
    end else begin
      bit hs, nb, found, set, clr;
      int nch, nst, nptr, c;
      bit ns [N];
      int nstamp [N];
      hs = m_busy && rpt_ready;
      nb = m_busy; nch = m_ch; nst = m_st; nptr = m_ptr;
      found = 1'b0;
      if (m_busy) begin
        if (hs) begin
          exp_q.push_back(rec(m_ch, m_st));
          nptr = (m_ch + 1) % N;
          nb   = 1'b0;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (!found && m_sticky[c]) begin
            found = 1'b1; nb = 1'b1; nch = c; nst = m_stamp[c];
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        set = ev_in[i] && enable[i];
        clr = hs && (m_ch == i);
        ns[i] = m_sticky[i];
        nstamp[i] = m_stamp[i];
        if (clr) ns[i] = 1'b0;
        if (set) begin
          if (!m_sticky[i] || clr) nstamp[i] = m_tcnt;
          ns[i] = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) begin
        m_sticky[i] = ns[i];
        m_stamp[i]  = nstamp[i];
      end
      m_busy = nb; m_ch = nch; m_st = nst; m_ptr = nptr;
      m_tcnt = (m_tcnt + 1) % 256;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      logic [N-1:0] es;
      for (int i = 0; i < N; i++) es[i] = m_sticky[i];
      chk("cyc_sticky", sticky, es);
      chk("cyc_any_sticky", any_sticky, |es);
      chk("cyc_rpt_valid", rpt_valid, m_busy);
      if (m_busy) begin
        chk("cyc_rpt_ch", rpt_ch, m_ch);
        chk("cyc_rpt_stamp", rpt_stamp, m_st);
      end
      if (rpt_valid && rpt_ready) begin
        got_q.push_back({rpt_ch, rpt_stamp});
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0; ev_in = '0; enable = '1; rpt_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int base;
    rst = 1'b0;
    tick();
    tick();
    chk("rst_sticky", sticky, 0);
    chk("rst_any", any_sticky, 0);
    chk("rst_valid", rpt_valid, 0);
    chk("rst_ch", rpt_ch, 0);
    chk("rst_stamp", rpt_stamp, 0);
    rst = 1'b1;

    // First event at tcnt=5 reported as ch0 stamp 5
    rpt_ready = 1'b1;
    repeat (5) tick();
    ev_in = 4'b0001;
    tick();
    ev_in = '0;
    chk("first_sticky", sticky, 4'b0001);
    tick();
    chk("first_valid", rpt_valid, 1);
    chk("first_ch", rpt_ch, 0);
    chk("first_stamp", rpt_stamp, 5);
    tick();
    chk("first_cleared", sticky, 0);
    chk("first_idle", rpt_valid, 0);
    chk("first_log", got_at(0), rec(0, 5));

    // All four at once: order 0..3, two cycles apart, then 0,1 again
    do_reset();
    rpt_ready = 1'b1;
    base = got_q.size();
    ev_in = 4'b1111;
    tick();
    ev_in = '0;
    repeat (10) tick();
    chk("rr_count", got_q.size(), base + 4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_entry", got_at(base + i), rec(i, 0));
      if (i > 0) chk("rr_spacing", cyc_at(base + i) - cyc_at(base + i - 1), 2);
    end
    base = got_q.size();
    ev_in = 4'b0011;
    tick();
    ev_in = '0;
    repeat (6) tick();
    chk("rr2_count", got_q.size(), base + 2);
    chk("rr2_ch0", got_at(base)[TW+CW-1:TW], 0);
    chk("rr2_ch1", got_at(base + 1)[TW+CW-1:TW], 1);

    // Stalled consumer with ch2 pulsing: one stable report
    do_reset();
    rpt_ready = 1'b0;
    base = got_q.size();
    ev_in = 4'b0100;
    tick();
    ev_in = '0;
    tick();
    for (int i = 0; i < 10; i++) begin
      ev_in = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      chk("stall_valid", rpt_valid, 1);
      chk("stall_ch", rpt_ch, 2);
      chk("stall_stamp", rpt_stamp, 0);
      tick();
    end
    ev_in = '0;
    rpt_ready = 1'b1;
    repeat (5) tick();
    chk("stall_count", got_q.size(), base + 1);
    chk("stall_entry", got_at(base), rec(2, 0));
    chk("stall_sticky", sticky, 0);

    // Continuous ch1: set beats clear, restamped at each handshake
    do_reset();
    rpt_ready = 1'b1;
    base = got_q.size();
    ev_in = 4'b0010;
    repeat (3) tick();
    chk("cont_sticky", sticky, 4'b0010);
    repeat (4) tick();
    ev_in = '0;
    repeat (6) tick();
    chk("cont_count", got_q.size(), base + 4);
    for (int i = 0; i < 4; i++) chk("cont_entry", got_at(base + i), rec(1, 2 * i));

    // Disabled channel ignored; stamp captured at tcnt=255 before wrap
    do_reset();
    rpt_ready = 1'b1;
    enable = 4'b1110;
    ev_in = 4'b0001;
    repeat (3) tick();
    chk("dis_sticky", sticky, 0);
    ev_in = '0;
    for (int i = 0; i < 300 && m_tcnt != 255; i++) tick();
    chk("wrap_reach", m_tcnt, 255);
    base = got_q.size();
    ev_in = 4'b0010;
    tick();
    ev_in = '0;
    repeat (4) tick();
    chk("wrap_count", got_q.size(), base + 1);
    chk("wrap_entry", got_at(base), rec(1, 255));
    rpt_ready = 1'b0;
    enable = 4'b1000;
    ev_in = 4'b1000;
    tick();
    ev_in = '0;
    enable = 4'b0000;
    repeat (3) tick();
    chk("dis_keeps", sticky, 4'b1000);
    enable = '1;
    rpt_ready = 1'b1;
    repeat (4) tick();
    chk("dis_drained", sticky, 0);

    // Reset while a report is pending
    do_reset();
    rpt_ready = 1'b0;
    ev_in = 4'b0100;
    tick();
    ev_in = '0;
    tick();
    chk("mid_valid_pre", rpt_valid, 1);
    #1 rst = 1'b0;
    #1;
    chk("mid_sticky", sticky, 0);
    chk("mid_any", any_sticky, 0);
    chk("mid_valid", rpt_valid, 0);
    chk("mid_ch", rpt_ch, 0);
    chk("mid_stamp", rpt_stamp, 0);
    tick();
    rst = 1'b1;
    rpt_ready = 1'b1;
    base = got_q.size();
    ev_in = 4'b1000;
    tick();
    ev_in = '0;
    repeat (4) tick();
    chk("post_count", got_q.size(), base + 1);
    chk("post_entry", got_at(base), rec(3, 0));

    chk("log_size", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) chk("log_entry", got_at(i), exp_q[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
